// File: rtl/uart_tx_queue.sv
// Circular byte FIFO that launches one UART frame at a time via a toggle trigger.
// Define UART_TXQ_TIMEOUT_EN to abandon frames whose finish never arrives.
module uart_tx_queue #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 2000000
) (
    input  logic            sysclk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [7:0]      wr_data,
    output logic            full,
    output logic            empty,
    output logic [ADDR_W:0] count,
    output logic            busy,
    output logic            overflow,
    input  logic            clr_ovf,
    output logic            timeout,
    output logic [7:0]      tx_data,
    output logic            tx_trigger,
    output logic            tx_enable,
    input  logic            tx_finish
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LOAD      = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   count_q;
    logic              finish_q;
    logic              fin_rise;
    logic              pop;
    logic              push;
    logic              drop;
    logic              frame_abandon;

    assign full      = (count_q == FULL_COUNT);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign busy      = (state != IDLE);
    assign tx_enable = (state == LOAD) || (state == WAIT_DONE);

    // A full queue still accepts a write on the pop edge because a slot frees up.
    assign pop      = (state == IDLE) && !empty;
    assign push     = wr_en && (!full || pop);
    assign drop     = wr_en && full && !pop;
    assign fin_rise = tx_finish && !finish_q;

`ifdef UART_TXQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             timeout_q;

    // The frame is dropped on the edge where the count would reach TIMEOUT.
    assign frame_abandon = (state == WAIT_DONE) && !fin_rise && (tmo_cnt == TMO_LAST);
    assign timeout       = timeout_q;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (state != WAIT_DONE) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            timeout_q <= 1'b0;
        end else if (clr_ovf) begin
            timeout_q <= 1'b0;
        end else if (frame_abandon) begin
            timeout_q <= 1'b1;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;

    assign frame_abandon = 1'b0;
    assign timeout       = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (!empty) state_nx = LOAD;
            LOAD:      state_nx = WAIT_DONE;
            WAIT_DONE: if (fin_rise || frame_abandon) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            finish_q <= 1'b0;
        end else begin
            state    <= state_nx;
            finish_q <= tx_finish;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // tx_data is loaded one edge ahead of the toggle so it is stable when sampled.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            tx_data    <= 8'h00;
            tx_trigger <= 1'b0;
        end else begin
            if (pop) tx_data <= mem[rd_ptr];
            if (state == LOAD) tx_trigger <= ~tx_trigger;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

endmodule
